// File: rtl/colour_sched_pkg.sv
// Shared types and constants for the colour scheduler: FSM state,
// requester select and the default colour width.
package colour_sched_pkg;

  localparam int DEFAULT_COLOUR_WIDTH = 16;

  typedef enum logic {
    IDLE,
    STAGED
  } state_t;

  typedef enum logic [1:0] {
    NONE,
    BUS,
    SW,
    TICK
  } req_sel_t;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler: one-cycle TICK every TICK_MAX cycles while ENABLE is high.
// Dropping ENABLE clears the count so the next period starts from zero.
module tick_prescaler #(
  parameter int TICK_WIDTH = 27,
  parameter int TICK_MAX   = 100000000
) (
  input  logic CLK,
  input  logic RESETN,
  input  logic ENABLE,
  output logic TICK
);

  localparam logic [TICK_WIDTH-1:0] LAST_COUNT = TICK_WIDTH'(TICK_MAX - 1);

  logic [TICK_WIDTH-1:0] count_reg;
  logic [TICK_WIDTH-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (!ENABLE) begin
      count_next = '0;
    end else if (count_reg == LAST_COUNT) begin
      count_next = '0;
    end else begin
      count_next = count_reg + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign TICK = ENABLE && (count_reg == LAST_COUNT);

endmodule

// File: rtl/colour_scheduler.sv
// Arbitrates bus / switch / auto-step writes to the display colour register and
// commits them at frame boundaries when COLOUR_SCHED_FRAME_SYNC_EN is defined.
module colour_scheduler
  import colour_sched_pkg::*;
#(
  parameter int                       COLOUR_WIDTH = DEFAULT_COLOUR_WIDTH,
  parameter int                       TICK_WIDTH   = 27,
  parameter int                       TICK_MAX     = 100000000,
  parameter int                       STEP         = 10,
  parameter logic [COLOUR_WIDTH-1:0]  RESET_COLOUR = '0
) (
  input  logic                    CLK,
  input  logic                    RESETN,
  input  logic                    BUS_REQ,
  input  logic [COLOUR_WIDTH-1:0] BUS_DATA,
  output logic                    BUS_ACK,
  input  logic                    SW_LOAD,
  input  logic [COLOUR_WIDTH-1:0] SW_COLOUR,
  input  logic                    AUTO_EN,
  input  logic                    FRAME_END,
  output logic [COLOUR_WIDTH-1:0] COLOUR_OUT,
  output logic                    PENDING
);

  state_t                  state_reg, state_next;
  logic [COLOUR_WIDTH-1:0] staged_reg, staged_next;
  logic [COLOUR_WIDTH-1:0] colour_reg, colour_next;
  logic                    ack_reg, ack_next;

  req_sel_t                sel;
  logic [COLOUR_WIDTH-1:0] base_value;
  logic [COLOUR_WIDTH-1:0] grant_value;
  logic                    tick;
  logic                    commit;

  tick_prescaler #(
    .TICK_WIDTH (TICK_WIDTH),
    .TICK_MAX   (TICK_MAX)
  ) u_prescaler (
    .CLK    (CLK),
    .RESETN (RESETN),
    .ENABLE (AUTO_EN),
    .TICK   (tick)
  );

  // Auto-step accumulates on the staged value so repeated ticks before a commit add up.
  assign base_value = (state_reg == STAGED) ? staged_reg : colour_reg;

  always_comb begin
    sel         = NONE;
    grant_value = staged_reg;
    if (BUS_REQ && !ack_reg) begin
      sel         = BUS;
      grant_value = BUS_DATA;
    end else if (SW_LOAD) begin
      sel         = SW;
      grant_value = SW_COLOUR;
    end else if (tick) begin
      sel         = TICK;
      grant_value = base_value + COLOUR_WIDTH'(STEP);
    end
  end

`ifdef COLOUR_SCHED_FRAME_SYNC_EN
  assign commit = (state_reg == STAGED) && FRAME_END;
`else
  // Without frame sync every staged value commits on the following cycle.
  assign commit = (state_reg == STAGED) && (FRAME_END || 1'b1);
`endif

  always_comb begin
    state_next  = state_reg;
    staged_next = staged_reg;
    colour_next = colour_reg;
    ack_next    = (sel == BUS);
    unique case (state_reg)
      IDLE: begin
        if (sel != NONE) begin
          staged_next = grant_value;
          state_next  = STAGED;
        end
      end
      STAGED: begin
        if (commit) begin
          colour_next = staged_reg;
          if (sel != NONE) begin
            staged_next = grant_value;
          end else begin
            state_next = IDLE;
          end
        end else if (sel != NONE) begin
          staged_next = grant_value;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_reg  <= IDLE;
      staged_reg <= '0;
      colour_reg <= RESET_COLOUR;
      ack_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      staged_reg <= staged_next;
      colour_reg <= colour_next;
      ack_reg    <= ack_next;
    end
  end

  assign COLOUR_OUT = colour_reg;
  assign PENDING    = (state_reg == STAGED);
  assign BUS_ACK    = ack_reg;

endmodule

// File: tb/tb_colour_scheduler.sv
// Self-checking bench for colour_scheduler: vector table, corner sequences and
// randomized traffic against a rule-level reference model (either frame-sync build).
module tb_colour_scheduler;

  localparam int TB_TICK_MAX = 4;
  localparam int TB_STEP     = 10;

  logic        CLK = 1'b0;
  logic        RESETN = 1'b0;
  logic        BUS_REQ = 1'b0;
  logic [15:0] BUS_DATA = '0;
  logic        BUS_ACK;
  logic        SW_LOAD = 1'b0;
  logic [15:0] SW_COLOUR = '0;
  logic        AUTO_EN = 1'b0;
  logic        FRAME_END = 1'b0;
  logic [15:0] COLOUR_OUT;
  logic        PENDING;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [15:0] m_colour = '0;
  logic [15:0] m_staged = '0;
  logic        m_pend = 1'b0;
  logic        m_ack = 1'b0;
  int          m_cnt = 0;

  colour_scheduler #(
    .COLOUR_WIDTH (16),
    .TICK_WIDTH   (3),
    .TICK_MAX     (TB_TICK_MAX),
    .STEP         (TB_STEP),
    .RESET_COLOUR (16'h0000)
  ) dut (
    .CLK        (CLK),
    .RESETN     (RESETN),
    .BUS_REQ    (BUS_REQ),
    .BUS_DATA   (BUS_DATA),
    .BUS_ACK    (BUS_ACK),
    .SW_LOAD    (SW_LOAD),
    .SW_COLOUR  (SW_COLOUR),
    .AUTO_EN    (AUTO_EN),
    .FRAME_END  (FRAME_END),
    .COLOUR_OUT (COLOUR_OUT),
    .PENDING    (PENDING)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_colour = 16'h0000;
    m_staged = '0;
    m_pend   = 1'b0;
    m_ack    = 1'b0;
    m_cnt    = 0;
  endtask

  // One clock of the scheduler's rules: pick the winner, commit, stage.
  task automatic model_step(input logic req, input logic [15:0] bd, input logic swl,
                            input logic [15:0] swc, input logic ae, input logic fe);
    logic        tick_now;
    logic        bus_win;
    logic        win;
    logic        commit_now;
    logic [15:0] val;
    tick_now = ae && (m_cnt == TB_TICK_MAX - 1);
    m_cnt    = ae ? (m_cnt + 1) % TB_TICK_MAX : 0;
    bus_win  = req && !m_ack;
    win      = 1'b1;
    val      = '0;
    if (bus_win)       val = bd;
    else if (swl)      val = swc;
    else if (tick_now) val = (m_pend ? m_staged : m_colour) + 16'(TB_STEP);
    else               win = 1'b0;
`ifdef COLOUR_SCHED_FRAME_SYNC_EN
    commit_now = m_pend && fe;
`else
    commit_now = m_pend;
`endif
    if (commit_now) m_colour = m_staged;
    if (win)        m_staged = val;
    m_pend = win || (m_pend && !commit_now);
    m_ack  = bus_win;
  endtask

  task automatic step(input logic req, input logic [15:0] bd, input logic swl,
                      input logic [15:0] swc, input logic ae, input logic fe);
    BUS_REQ   = req;
    BUS_DATA  = bd;
    SW_LOAD   = swl;
    SW_COLOUR = swc;
    AUTO_EN   = ae;
    FRAME_END = fe;
    model_step(req, bd, swl, swc, ae, fe);
    @(posedge CLK);
    #1;
    $display("t=%0t req=%b bd=%h swl=%b swc=%h ae=%b fe=%b -> colour=%h pend=%b ack=%b",
             $time, req, bd, swl, swc, ae, fe, COLOUR_OUT, PENDING, BUS_ACK);
    check("colour", COLOUR_OUT, m_colour);
    check("pending", {15'd0, PENDING}, {15'd0, m_pend});
    check("ack", {15'd0, BUS_ACK}, {15'd0, m_ack});
    check("staged", dut.staged_reg, m_staged);
  endtask

  task automatic idle(input logic ae, input logic fe);
    step(1'b0, 16'h0000, 1'b0, 16'h0000, ae, fe);
  endtask

  typedef struct {
    logic        req;
    logic [15:0] bd;
    logic        swl;
    logic [15:0] swc;
    logic        ae;
    logic        fe;
    logic [15:0] exp_colour;
    logic        exp_pend;
    logic        exp_ack;
  } vec_t;

  vec_t vecs [14];

  logic        r_req;
  logic [15:0] r_bd;
  logic        r_swl;
  logic [15:0] r_swc;
  logic        r_ae;
  logic        r_fe;

  initial begin
    // reset, first auto tick, bus write + commit, three-way collision, switch load
    vecs[0]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h000A, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 16'hF800, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h000A, 1'b1, 1'b1};
    vecs[6]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'hF800, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'hF800, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'hF800, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'hF800, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 16'h1111, 1'b1, 16'h07E0, 1'b1, 1'b0, 16'hF800, 1'b1, 1'b1};
    vecs[11] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h1111, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 16'h0000, 1'b1, 16'hFFFC, 1'b0, 1'b0, 16'h1111, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'hFFFC, 1'b0, 1'b0};

    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    check("reset_colour", COLOUR_OUT, 16'h0000);
    check("reset_pending", {15'd0, PENDING}, 16'h0000);
    check("reset_ack", {15'd0, BUS_ACK}, 16'h0000);
    RESETN = 1'b1;

    for (int i = 0; i < 14; i++) begin
      step(vecs[i].req, vecs[i].bd, vecs[i].swl, vecs[i].swc, vecs[i].ae, vecs[i].fe);
      check($sformatf("vec%0d_colour", i), COLOUR_OUT, vecs[i].exp_colour);
      check($sformatf("vec%0d_pending", i), {15'd0, PENDING}, {15'd0, vecs[i].exp_pend});
      check($sformatf("vec%0d_ack", i), {15'd0, BUS_ACK}, {15'd0, vecs[i].exp_ack});
    end

    // three auto ticks from 16'hFFFC wrap through zero: FFFC+30 = 001A mod 2^16
    for (int i = 0; i < 12; i++) idle(1'b1, 1'b0);
`ifdef COLOUR_SCHED_FRAME_SYNC_EN
    check("accum_staged", dut.staged_reg, 16'h001A);
    check("accum_hold", COLOUR_OUT, 16'hFFFC);
`else
    check("accum_staged", dut.staged_reg, 16'h001A);
    check("accum_partial", COLOUR_OUT, 16'h0010);
`endif
    idle(1'b0, 1'b1);
    check("accum_commit", COLOUR_OUT, 16'h001A);

    // switch load coincident with a commit re-stages and keeps PENDING
    step(1'b0, 16'h0000, 1'b1, 16'h1234, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 16'h001F, 1'b0, 1'b1);
    check("simul_colour", COLOUR_OUT, 16'h1234);
    check("simul_pending", {15'd0, PENDING}, 16'h0001);
    check("simul_staged", dut.staged_reg, 16'h001F);
    idle(1'b0, 1'b1);
    check("simul_commit", COLOUR_OUT, 16'h001F);

    // commit timing without FRAME_END depends on the build
    step(1'b0, 16'h0000, 1'b1, 16'hABCD, 1'b0, 1'b0);
    idle(1'b0, 1'b0);
`ifdef COLOUR_SCHED_FRAME_SYNC_EN
    check("nofe_colour", COLOUR_OUT, 16'h001F);
    check("nofe_pending", {15'd0, PENDING}, 16'h0001);
`else
    check("nofe_colour", COLOUR_OUT, 16'hABCD);
    check("nofe_pending", {15'd0, PENDING}, 16'h0000);
`endif
    idle(1'b0, 1'b1);
    check("nofe_commit", COLOUR_OUT, 16'hABCD);

    // held REQ is granted at most every other cycle
    step(1'b1, 16'h5555, 1'b0, 16'h0000, 1'b0, 1'b0);
    step(1'b1, 16'h5555, 1'b0, 16'h0000, 1'b0, 1'b0);
    check("held_no_regrant", {15'd0, BUS_ACK}, 16'h0000);
    step(1'b1, 16'h5555, 1'b0, 16'h0000, 1'b0, 1'b0);
    check("held_regrant", {15'd0, BUS_ACK}, 16'h0001);
    idle(1'b0, 1'b1);

    // asynchronous reset while PENDING and BUS_ACK are high
    step(1'b1, 16'h7777, 1'b0, 16'h0000, 1'b1, 1'b0);
    RESETN = 1'b0;
    #2;
    model_reset();
    check("midrst_colour", COLOUR_OUT, 16'h0000);
    check("midrst_pending", {15'd0, PENDING}, 16'h0000);
    check("midrst_ack", {15'd0, BUS_ACK}, 16'h0000);
    check("midrst_staged", dut.staged_reg, 16'h0000);
    @(posedge CLK);
    #1;
    RESETN = 1'b1;
    step(1'b1, 16'h7777, 1'b0, 16'h0000, 1'b0, 1'b0);
    check("midrst_regrant", {15'd0, BUS_ACK}, 16'h0001);
    idle(1'b0, 1'b1);
    check("midrst_commit", COLOUR_OUT, 16'h7777);

    // randomized traffic with a well-behaved bus requester
    r_req = 1'b0;
    r_bd  = '0;
    r_ae  = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (BUS_ACK) begin
        r_req = 1'b0;
      end else if (!r_req && $urandom_range(0, 3) == 0) begin
        r_req = 1'b1;
        r_bd  = 16'($urandom);
      end
      r_swl = ($urandom_range(0, 5) == 0);
      r_swc = ($urandom_range(0, 1) == 1) ? (16'hFFF0 | 16'($urandom_range(0, 15))) : 16'($urandom);
      if ($urandom_range(0, 15) == 0) r_ae = ~r_ae;
      r_fe = ($urandom_range(0, 4) == 0);
      step(r_req, r_bd, r_swl, r_swc, r_ae, r_fe);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
